// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional-N baud tick generator.
package baud_pkg;

  localparam logic [63:0] CLK_FREQ_HZ = 64'd100_000_000;
  localparam int          OSR_MIN     = 2;

  // Rounded phase increment so that f_clk*inc/2^acc_w = baud*osr.
  function automatic logic [63:0] calc_inc(input logic [63:0] clk_hz,
                                           input logic [63:0] baud,
                                           input logic [63:0] osr,
                                           input int          acc_w);
    logic [63:0] num;
    num = (baud * osr) << acc_w;
    return (num + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Phase accumulator: adds inc every enabled cycle; carry_o flags the wrap at the upcoming edge.
module baud_phase_acc
  import baud_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_i};
    acc_d   = sum[ACC_W-1:0];
    carry_o = sum[ACC_W];
    if (!en_i || clear_i) begin
      acc_d   = '0;
      carry_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator with shadowed config and RX resync.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int          ACC_W   = 24,
  parameter int          OSR_W   = 5,
  parameter int unsigned DEF_INC = 32'(calc_inc(CLK_FREQ_HZ, 64'd9600, 64'd16, ACC_W)),
  parameter int unsigned DEF_OSR = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic             cfg_load,
  output logic             cfg_busy,
  input  logic             resync,
  output logic             tick_os,
  output logic             tick_1x,
  output logic [OSR_W-1:0] sample_idx
);

  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(DEF_INC);
  localparam logic [OSR_W-1:0] OSR_RST = OSR_W'(DEF_OSR);

  function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] r);
    return (r < OSR_W'(OSR_MIN)) ? OSR_W'(OSR_MIN) : r;
  endfunction

  logic [ACC_W-1:0] inc_q, inc_d, inc_s_q, inc_s_d;
  logic [OSR_W-1:0] osr_q, osr_d, osr_s_q, osr_s_d;
  logic [OSR_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_1x_q, tick_1x_d;
  logic             carry, wrap, apply;

  baud_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .clear_i (resync),
    .inc_i   (inc_q),
    .carry_o (carry)
  );

  // Config swaps happen only at a bit boundary, so idx_q never exceeds the new osr-1.
  assign wrap  = carry && (idx_q == osr_q - OSR_W'(1));
  assign apply = pending_q && (!en || resync || wrap);

  always_comb begin
    inc_d     = inc_q;
    osr_d     = osr_q;
    inc_s_d   = inc_s_q;
    osr_s_d   = osr_s_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    tick_os_d = 1'b0;
    tick_1x_d = 1'b0;

    if (!en || resync) begin
      idx_d = '0;
    end else if (carry) begin
      tick_os_d = 1'b1;
      if (wrap) begin
        idx_d     = '0;
        tick_1x_d = 1'b1;
      end else begin
        idx_d = idx_q + OSR_W'(1);
      end
    end

    if (apply) begin
      inc_d     = inc_s_q;
      osr_d     = osr_s_q;
      pending_d = 1'b0;
    end
    // A load coinciding with an apply re-arms pending with the fresh values.
    if (cfg_load) begin
      inc_s_d   = cfg_inc;
      osr_s_d   = clamp_osr(cfg_osr);
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q     <= INC_RST;
      osr_q     <= OSR_RST;
      inc_s_q   <= INC_RST;
      osr_s_q   <= OSR_RST;
      pending_q <= 1'b0;
      idx_q     <= '0;
      tick_os_q <= 1'b0;
      tick_1x_q <= 1'b0;
    end else begin
      inc_q     <= inc_d;
      osr_q     <= osr_d;
      inc_s_q   <= inc_s_d;
      osr_s_q   <= osr_s_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      tick_os_q <= tick_os_d;
      tick_1x_q <= tick_1x_d;
    end
  end

  assign cfg_busy   = pending_q;
  assign tick_os    = tick_os_q;
  assign tick_1x    = tick_1x_q;
  assign sample_idx = idx_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: closed-form tick scoreboard plus corner sequences.
module tb_baud_gen_frac;

  localparam int AW = 8;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, cfg_load = 1'b0, resync = 1'b0;
  logic [AW-1:0] cfg_inc = '0;
  logic [OW-1:0] cfg_osr = '0;
  logic          cfg_busy, tick_os, tick_1x;
  logic [OW-1:0] sample_idx;

  logic          en_d = 1'b0, cfg_load_d = 1'b0, resync_d = 1'b0;
  logic [23:0]   cfg_inc_d = '0;
  logic [4:0]    cfg_osr_d = '0;
  logic          busy_d, tos_d, t1x_d;
  logic [4:0]    idx_d;

  baud_gen_frac #(.ACC_W(AW), .OSR_W(OW), .DEF_INC(64), .DEF_OSR(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_inc(cfg_inc), .cfg_osr(cfg_osr),
    .cfg_load(cfg_load), .cfg_busy(cfg_busy), .resync(resync),
    .tick_os(tick_os), .tick_1x(tick_1x), .sample_idx(sample_idx)
  );

  baud_gen_frac dut_def (
    .clk(clk), .rst(rst), .en(en_d), .cfg_inc(cfg_inc_d), .cfg_osr(cfg_osr_d),
    .cfg_load(cfg_load_d), .cfg_busy(busy_d), .resync(resync_d),
    .tick_os(tos_d), .tick_1x(t1x_d), .sample_idx(idx_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] inc;
    logic [OW-1:0] osr;
    int            cycles;
    int            n_tos;
    int            n_1x;
  } vec_t;

  typedef struct packed {
    logic          tos;
    logic          t1x;
    logic          busy;
    logic [OW-1:0] idx;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t cur();
    obs_t o;
    o.tos  = tick_os;
    o.t1x  = tick_1x;
    o.busy = cfg_busy;
    o.idx  = sample_idx;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Park with en low, load a config and let the idle apply land.
  task automatic load_idle(input logic [AW-1:0] inc, input logic [OW-1:0] osr);
    en       = 1'b0;
    cfg_inc  = inc;
    cfg_osr  = osr;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    check("idle_state", cur(), '0);
  endtask

  // Tick n lands on the first edge c with floor(c*inc/2^AW) = n.
  task automatic run_seg(input logic [AW-1:0] inc, input logic [OW-1:0] osr, input int cycles,
                         input int n_tos, input int n_1x, input string name);
    longint n, n_prev;
    int     osr_eff, c_tos, c_1x;
    obs_t   e, g;
    osr_eff = (osr < 2) ? 2 : int'(osr);
    n_prev  = 0;
    c_tos   = 0;
    c_1x    = 0;
    en      = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      n      = (longint'(c) * longint'(inc)) >> AW;
      e.tos  = (n != n_prev);
      e.idx  = OW'(n % osr_eff);
      e.t1x  = e.tos && (e.idx == '0);
      e.busy = 1'b0;
      sb.push_back(e);
      step();
      g = sb.pop_front();
      check($sformatf("%s c%0d", name, c), cur(), g);
      c_tos += int'(tick_os);
      c_1x  += int'(tick_1x);
      n_prev = n;
    end
    check($sformatf("%s tick_os_count", name), c_tos, n_tos);
    check($sformatf("%s tick_1x_count", name), c_1x, n_1x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   b_cnt, t_cnt, first;
    int   t1x_at[$];
    vt[0] = '{8'd64,  5'd4,  64,  16,  4};
    vt[1] = '{8'd96,  5'd4,  768, 288, 72};
    vt[2] = '{8'd32,  5'd8,  256, 32,  4};
    vt[3] = '{8'd0,   5'd4,  100, 0,   0};
    vt[4] = '{8'd255, 5'd3,  256, 255, 85};
    vt[5] = '{8'd200, 5'd31, 256, 200, 6};
    vt[6] = '{8'd128, 5'd1,  64,  32,  16};
    vt[7] = '{8'd64,  5'd0,  64,  16,  8};

    #12;
    check("reset_outputs", cur(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seg(8'd64, 5'd4, 64, 16, 4, "reset_cfg");

    for (int i = 0; i < 8; i++) begin
      load_idle(vt[i].inc, vt[i].osr);
      run_seg(vt[i].inc, vt[i].osr, vt[i].cycles, vt[i].n_tos, vt[i].n_1x, $sformatf("vec%0d", i));
    end

    // Config load mid-bit: held until the next bit boundary at edge 16.
    load_idle(8'd64, 5'd4);
    en = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    check("cfg_pre_idx", sample_idx, 1);
    cfg_inc  = 8'd32;
    cfg_osr  = 5'd8;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("cfg_busy_rise", cfg_busy, 1'b1);
    b_cnt = 0;
    t_cnt = 0;
    t1x_at.delete();
    for (int c = 6; c <= 80; c++) begin
      step();
      if (cfg_busy) b_cnt++;
      if (tick_1x) t1x_at.push_back(c);
      if (c > 16 && tick_os) t_cnt++;
    end
    check("cfg_busy_cycles", b_cnt, 10);
    check("cfg_tick_1x_count", t1x_at.size(), 2);
    if (t1x_at.size() == 2) begin
      check("cfg_apply_edge", t1x_at[0], 16);
      check("cfg_new_bit_edge", t1x_at[1], 80);
    end
    check("cfg_new_bit_ticks", t_cnt, 8);
    check("cfg_end_idx", sample_idx, 0);

    // Resync on the cycle that would otherwise carry.
    load_idle(8'd64, 5'd4);
    en = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_edge", cur(), '0);
    t_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      t_cnt += int'(tick_os);
    end
    check("resync_quiet", t_cnt, 0);
    step();
    check("resync_first_tick", cur(), obs_t'({1'b1, 1'b0, 1'b0, 5'd1}));

    // Enable dropped mid-bit with a config loaded while idle.
    load_idle(8'd64, 5'd4);
    en = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    en       = 1'b0;
    cfg_inc  = 8'd128;
    cfg_osr  = 5'd2;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("en_low_load", cur(), obs_t'({1'b0, 1'b0, 1'b1, 5'd0}));
    step();
    check("en_low_applied", cur(), '0);
    en = 1'b1;
    step();
    check("reen_e1", cur(), '0);
    step();
    check("reen_e2", cur(), obs_t'({1'b1, 1'b0, 1'b0, 5'd1}));
    step();
    check("reen_e3", cur(), obs_t'({1'b0, 1'b0, 1'b0, 5'd1}));
    step();
    check("reen_e4", cur(), obs_t'({1'b1, 1'b1, 1'b0, 5'd0}));

    // Asynchronous reset mid-operation restores defaults without a clock edge.
    load_idle(8'd96, 5'd8);
    en = 1'b1;
    for (int c = 1; c <= 10; c++) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", cur(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seg(8'd64, 5'd4, 32, 8, 2, "post_rst");
    en = 1'b0;

    // Default-parameter instance: 9600 baud x16 at 100 MHz.
    en_d  = 1'b1;
    first = 0;
    t_cnt = 0;
    b_cnt = 0;
    for (int c = 1; c <= 20000; c++) begin
      step();
      if (tos_d) begin
        t_cnt++;
        if (first == 0) first = c;
      end
      if (t1x_d) b_cnt++;
    end
    check("def_first_tick", first, 652);
    check("def_tick_os_count", t_cnt, 30);
    check("def_tick_1x_count", b_cnt, 1);
    check("def_idx", idx_d, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
